// File: rtl/pwm_ctrl_pkg.sv
// Shared constants, types and helpers for the PWM controller.
// Holds the register map, the reset values and the address decoder
// so that the top level and the bench agree on one definition.
package pwm_ctrl_pkg;

  // Register map (4-bit address space)
  localparam logic [3:0] ADDR_PERIOD = 4'd0;
  localparam logic [3:0] ADDR_ENABLE = 4'd1;
  localparam logic [3:0] ADDR_DUTY0  = 4'd2;

  // Reset values of the PERIOD and DUTY registers (shadow and active)
  localparam int unsigned PERIOD_RST = 32'd15;
  localparam int unsigned DUTY_RST   = 32'd0;

  // Which register class a write address selects
  typedef enum logic [1:0] {
    WR_NONE   = 2'd0,
    WR_PERIOD = 2'd1,
    WR_ENABLE = 2'd2,
    WR_DUTY   = 2'd3
  } wr_kind_e;

  // Classify an address; anything outside the map decodes to WR_NONE
  // so that the caller can treat it as "no state change".
  function automatic wr_kind_e decode_addr(input logic [3:0] addr,
                                           input int unsigned num_ch);
    wr_kind_e kind;
    if (addr == ADDR_PERIOD) begin
      kind = WR_PERIOD;
    end else if (addr == ADDR_ENABLE) begin
      kind = WR_ENABLE;
    end else if ((32'(addr) >= 32'(ADDR_DUTY0)) &&
                 (32'(addr) <  (32'(ADDR_DUTY0) + num_ch))) begin
      kind = WR_DUTY;
    end else begin
      kind = WR_NONE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/pwm_ctrl_if.sv
// Register-write bus and status outputs of the PWM controller.
// The master side (software / bench) issues writes and observes status;
// the slave side is the controller itself.
interface pwm_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);

  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [CNT_W-1:0]  wr_data;
  logic [NUM_CH-1:0] pwm_out;
  logic [CNT_W-1:0]  cnt;
  logic              period_tick;
  logic              upd_pend;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  pwm_out, cnt, period_tick, upd_pend
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output pwm_out, cnt, period_tick, upd_pend
  );

endinterface

// File: rtl/pwm_chan.sv
// One PWM channel: DUTY shadow register, DUTY active register and the
// registered compare output. The shared counter and the wrap strobe come
// from the controller; the active duty only changes in a wrap cycle, so a
// write in the wrap cycle itself lands one full period later.
module pwm_chan #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             wrap_i,
  input  logic             en_i,
  input  logic             wr_sel_i,
  input  logic [CNT_W-1:0] wr_data_i,
  output logic             pwm_o
);

  import pwm_ctrl_pkg::*;

  logic [CNT_W-1:0] duty_shd_q, duty_shd_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic             pwm_q,      pwm_d;

  // Next-state: shadow follows writes, active follows shadow at wrap,
  // output is the unsigned compare against the pre-edge counter.
  always_comb begin
    duty_shd_d = duty_shd_q;
    duty_act_d = duty_act_q;
    pwm_d      = 1'b0;
    if (wr_sel_i) begin
      duty_shd_d = wr_data_i;
    end else begin
      duty_shd_d = duty_shd_q;
    end
    if (wrap_i) begin
      duty_act_d = duty_shd_q;
    end else begin
      duty_act_d = duty_act_q;
    end
    pwm_d = en_i & (cnt_i < duty_act_q);
  end

  // Channel state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shd_q <= CNT_W'(DUTY_RST);
      duty_act_q <= CNT_W'(DUTY_RST);
      pwm_q      <= 1'b0;
    end else begin
      duty_shd_q <= duty_shd_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_ctrl.sv
// Multi-channel PWM controller with shadowed registers.
// A single up-counter runs from 0 to the active PERIOD and wraps; all
// active registers (PERIOD, ENABLE, every DUTY) reload from their shadows
// together in the wrap cycle so a period is never built from a mix of old
// and new settings. Writes only touch the shadows.
module pwm_ctrl #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  pwm_ctrl_if.slave  bus
);

  import pwm_ctrl_pkg::*;

  // Address decode
  wr_kind_e          wr_kind_s;
  logic              wr_valid_s;
  logic              wr_period_s;
  logic              wr_enable_s;
  logic [NUM_CH-1:0] wr_duty_sel_s;

  // Counter and wrap
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wrap_s;

  // PERIOD and ENABLE shadow / active registers
  logic [CNT_W-1:0]  per_shd_q, per_shd_d;
  logic [CNT_W-1:0]  per_act_q, per_act_d;
  logic [NUM_CH-1:0] en_shd_q,  en_shd_d;
  logic [NUM_CH-1:0] en_act_q,  en_act_d;

  // Status flags
  logic              tick_q, tick_d;
  logic              upd_pend_q, upd_pend_d;

  // Channel outputs
  logic [NUM_CH-1:0] pwm_s;

  assign wr_kind_s   = decode_addr(bus.wr_addr, NUM_CH);
  assign wr_valid_s  = bus.wr_en & (wr_kind_s != WR_NONE);
  assign wr_period_s = bus.wr_en & (wr_kind_s == WR_PERIOD);
  assign wr_enable_s = bus.wr_en & (wr_kind_s == WR_ENABLE);

  // The wrap cycle: counter has reached the active period. With a period
  // of zero this is true every cycle, which keeps period_tick high.
  assign wrap_s = (cnt_q == per_act_q);

  // Per-channel DUTY write select, one-hot over the DUTY address range
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_sel
      assign wr_duty_sel_s[gi] = bus.wr_en & (wr_kind_s == WR_DUTY) &
                                 (bus.wr_addr == 4'(32'(ADDR_DUTY0) + gi));
    end
  endgenerate

  // Counter next-state. If a shorter period was ever loaded while the
  // counter was already beyond it, the increment simply rolls over at
  // 2^CNT_W-1 and the counter re-enters the valid range from 0.
  always_comb begin
    cnt_d = cnt_q;
    if (wrap_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Shadow registers: updated by writes only, ENABLE upper bits dropped
  always_comb begin
    per_shd_d = per_shd_q;
    en_shd_d  = en_shd_q;
    if (wr_period_s) begin
      per_shd_d = bus.wr_data;
    end else begin
      per_shd_d = per_shd_q;
    end
    if (wr_enable_s) begin
      en_shd_d = bus.wr_data[NUM_CH-1:0];
    end else begin
      en_shd_d = en_shd_q;
    end
  end

  // Active registers: reload from the pre-write shadow value in a wrap
  // cycle, so a write landing in the wrap cycle waits a full period.
  always_comb begin
    per_act_d = per_act_q;
    en_act_d  = en_act_q;
    if (wrap_s) begin
      per_act_d = per_shd_q;
      en_act_d  = en_shd_q;
    end else begin
      per_act_d = per_act_q;
      en_act_d  = en_act_q;
    end
  end

  // Status: tick follows the wrap by one cycle; pending is set by any
  // valid write and cleared by a wrap that carries no new write.
  always_comb begin
    tick_d     = wrap_s;
    upd_pend_d = upd_pend_q;
    if (wr_valid_s) begin
      upd_pend_d = 1'b1;
    end else if (wrap_s) begin
      upd_pend_d = 1'b0;
    end else begin
      upd_pend_d = upd_pend_q;
    end
  end

  // Controller state registers; reset also drops any pending shadow write
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= {CNT_W{1'b0}};
      per_shd_q  <= CNT_W'(PERIOD_RST);
      per_act_q  <= CNT_W'(PERIOD_RST);
      en_shd_q   <= {NUM_CH{1'b0}};
      en_act_q   <= {NUM_CH{1'b0}};
      tick_q     <= 1'b0;
      upd_pend_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      per_shd_q  <= per_shd_d;
      per_act_q  <= per_act_d;
      en_shd_q   <= en_shd_d;
      en_act_q   <= en_act_d;
      tick_q     <= tick_d;
      upd_pend_q <= upd_pend_d;
    end
  end

  // One channel instance per PWM output
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      pwm_chan #(
        .CNT_W (CNT_W)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .cnt_i     (cnt_q),
        .wrap_i    (wrap_s),
        .en_i      (en_act_q[gi]),
        .wr_sel_i  (wr_duty_sel_s[gi]),
        .wr_data_i (bus.wr_data),
        .pwm_o     (pwm_s[gi])
      );
    end
  endgenerate

  assign bus.pwm_out     = pwm_s;
  assign bus.cnt         = cnt_q;
  assign bus.period_tick = tick_q;
  assign bus.upd_pend    = upd_pend_q;

endmodule

// File: tb/tb_pwm_ctrl.sv
// Directed self-checking bench for pwm_ctrl (NUM_CH=4, CNT_W=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// at the same point, i.e. they show the result of the edge just passed.
module tb_pwm_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pwm_ctrl_if #(.NUM_CH(4), .CNT_W(16)) bus ();

  pwm_ctrl #(
    .NUM_CH (4),
    .CNT_W  (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit
  initial begin
    #100000;
    $display("FAIL timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One register write, occupying exactly one clock edge
  task automatic wr(input logic [3:0] addr, input logic [15:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Advance until the cycle right after a wrap (bounded)
  task automatic wait_wrap();
    int guard;
    guard = 0;
    tick();
    while (!bus.period_tick && guard < 100) begin
      tick();
      guard++;
    end
    check_eq("wrap_seen", 32'(bus.period_tick), 32'd1);
  endtask

  // Starting right after a wrap (cnt==0), run n cycles and compare
  // against the closed-form waveform for fixed period/duty/enable.
  task automatic run_chk(input int n, input int per, input int d0,
                         input int d1, input int d2, input int d3,
                         input logic [3:0] en);
    int m;
    int ph;
    logic [3:0] exp_pwm;
    m = per + 1;
    for (int k = 1; k <= n; k++) begin
      tick();
      ph = (k - 1) % m;
      exp_pwm[0] = en[0] && (ph < d0);
      exp_pwm[1] = en[1] && (ph < d1);
      exp_pwm[2] = en[2] && (ph < d2);
      exp_pwm[3] = en[3] && (ph < d3);
      check_eq("cnt",  32'(bus.cnt), 32'(k % m));
      check_eq("tick", 32'(bus.period_tick), ((k % m) == 0) ? 32'd1 : 32'd0);
      check_eq("pwm",  32'(bus.pwm_out), 32'(exp_pwm));
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    // A write held during reset must be ignored
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd2;
    bus.wr_data = 16'd9;
    tick();
    tick();
    rst       = 1'b0;
    bus.wr_en = 1'b0;

    // Reset state
    check_eq("rst_cnt",  32'(bus.cnt), 32'd0);
    check_eq("rst_pwm",  32'(bus.pwm_out), 32'd0);
    check_eq("rst_tick", 32'(bus.period_tick), 32'd0);
    check_eq("rst_pend", 32'(bus.upd_pend), 32'd0);

    // Reset-default run: period 15, ticks at cycles 16 and 32, outputs low
    run_chk(40, 15, 0, 0, 0, 0, 4'h0);

    // Basic duty: PERIOD=9, ENABLE=1, DUTY0=3 (cnt now 8)
    wr(4'd0, 16'd9);
    check_eq("pend_set", 32'(bus.upd_pend), 32'd1);
    wr(4'd1, 16'd1);
    wr(4'd2, 16'd3);
    wait_wrap();
    check_eq("pend_clr", 32'(bus.upd_pend), 32'd0);
    check_eq("wrap_cnt", 32'(bus.cnt), 32'd0);
    run_chk(20, 9, 3, 0, 0, 0, 4'h1);

    // Shadow timing: DUTY0=7 at cnt==5 must not act before the wrap
    repeat (5) tick();
    check_eq("cnt5", 32'(bus.cnt), 32'd5);
    wr(4'd2, 16'd7);
    check_eq("pend_mid", 32'(bus.upd_pend), 32'd1);
    for (int j = 0; j < 3; j++) begin
      tick();
      check_eq("old_duty", 32'(bus.pwm_out), 32'd0);
    end
    check_eq("cnt9", 32'(bus.cnt), 32'd9);
    // DUTY0=1 written in the wrap cycle: 7 loads now, 1 one period later
    wr(4'd2, 16'd1);
    check_eq("pend_keep", 32'(bus.upd_pend), 32'd1);
    check_eq("wrap_tick", 32'(bus.period_tick), 32'd1);
    run_chk(10, 9, 7, 0, 0, 0, 4'h1);
    check_eq("pend_clr2", 32'(bus.upd_pend), 32'd0);
    run_chk(10, 9, 1, 0, 0, 0, 4'h1);

    // Extremes: DUTY1=0, DUTY2=10 (> period), all enabled
    wr(4'd3, 16'd0);
    wr(4'd4, 16'd10);
    wr(4'd1, 16'h00FF);
    wait_wrap();
    run_chk(20, 9, 1, 0, 10, 0, 4'hF);

    // PERIOD=0: every cycle is a wrap, tick held high
    wr(4'd0, 16'd0);
    wait_wrap();
    check_eq("p0_pend", 32'(bus.upd_pend), 32'd0);
    run_chk(5, 0, 1, 0, 10, 0, 4'hF);
    // Restore PERIOD=9; the write-cycle wrap still loads the old 0
    wr(4'd0, 16'd9);
    check_eq("p0_wr_pend", 32'(bus.upd_pend), 32'd1);
    check_eq("p0_wr_cnt",  32'(bus.cnt), 32'd0);
    wait_wrap();
    check_eq("p9_pend", 32'(bus.upd_pend), 32'd0);
    run_chk(10, 9, 1, 0, 10, 0, 4'hF);

    // Invalid addresses: 15 and 6 (first address past DUTY3)
    wr(4'd15, 16'h1234);
    check_eq("inv15_pend", 32'(bus.upd_pend), 32'd0);
    wr(4'd6, 16'd5);
    check_eq("inv6_pend", 32'(bus.upd_pend), 32'd0);
    wait_wrap();
    check_eq("inv_pend_w", 32'(bus.upd_pend), 32'd0);
    run_chk(10, 9, 1, 0, 10, 0, 4'hF);

    // Reset at cnt==6 with a pending DUTY0 write
    repeat (5) tick();
    wr(4'd2, 16'd5);
    check_eq("pre_rst_cnt",  32'(bus.cnt), 32'd6);
    check_eq("pre_rst_pend", 32'(bus.upd_pend), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_cnt",  32'(bus.cnt), 32'd0);
    check_eq("mrst_pwm",  32'(bus.pwm_out), 32'd0);
    check_eq("mrst_tick", 32'(bus.period_tick), 32'd0);
    check_eq("mrst_pend", 32'(bus.upd_pend), 32'd0);
    // Enable ch0 only: lost DUTY0 write leaves duty at 0, period back to 15
    wr(4'd1, 16'd1);
    check_eq("post_rst_cnt", 32'(bus.cnt), 32'd1);
    wait_wrap();
    run_chk(16, 15, 0, 0, 0, 0, 4'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
